// File: rtl/pc_sequencer.sv
// Instruction sequencer: drives an external program counter through a
// fetch/execute/advance cycle, with a 4-deep return stack for call/ret.
module pc_sequencer (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic        jmp,
  input  logic        call,
  input  logic        ret,
  input  logic        halt,
  input  logic [11:0] addr,
  input  logic [11:0] pc,
  output logic        pc_en,
  output logic        pc_load,
  output logic [11:0] pc_load_data,
  output logic        fetch,
  output logic        halted,
  output logic        err,
  output logic [2:0]  depth
);

  localparam int STACK_DEPTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    ADV,
    LOAD,
    HALT
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [11:0] load_data_reg;
  logic [11:0] load_data_next;
  logic [2:0]  depth_reg;
  logic [2:0]  depth_next;
  logic        err_reg;
  logic        err_next;
  logic        push;
  logic [11:0] stack_reg [STACK_DEPTH];
  logic [1:0]  top_idx;
  logic [11:0] return_addr;

  // depth is 1..4 whenever a pop happens, so the low two bits minus one
  // always name the top entry (4 wraps to index 3).
  assign top_idx     = depth_reg[1:0] - 2'd1;
  assign return_addr = pc + 12'd1;

  always_comb begin
    state_next     = state_reg;
    load_data_next = load_data_reg;
    depth_next     = depth_reg;
    err_next       = err_reg;
    push           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = FETCH;
      end
      FETCH: begin
        state_next = EXEC;
      end
      EXEC: begin
        if (halt) begin
          state_next = HALT;
        end else if (ret) begin
          if (depth_reg == 3'd0) begin
            err_next   = 1'b1;
            state_next = HALT;
          end else begin
            load_data_next = stack_reg[top_idx];
            depth_next     = depth_reg - 3'd1;
            state_next     = LOAD;
          end
        end else if (call) begin
          if (depth_reg == 3'(STACK_DEPTH)) begin
            err_next   = 1'b1;
            state_next = HALT;
          end else begin
            push           = 1'b1;
            load_data_next = addr;
            depth_next     = depth_reg + 3'd1;
            state_next     = LOAD;
          end
        end else if (jmp) begin
          load_data_next = addr;
          state_next     = LOAD;
        end else begin
          state_next = ADV;
        end
      end
      ADV: begin
        state_next = FETCH;
      end
      LOAD: begin
        state_next = FETCH;
      end
      HALT: begin
        if (start) state_next = FETCH;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg     <= IDLE;
      load_data_reg <= 12'h000;
      depth_reg     <= 3'd0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      load_data_reg <= load_data_next;
      depth_reg     <= depth_next;
      err_reg       <= err_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
      always_ff @(posedge CLK) begin
        if (reset) begin
          stack_reg[gi] <= 12'h000;
        end else if (push && (depth_reg[1:0] == 2'(gi))) begin
          stack_reg[gi] <= return_addr;
        end
      end
    end
  endgenerate

  assign fetch        = (state_reg == FETCH);
  assign pc_en        = (state_reg == ADV);
  assign pc_load      = (state_reg == LOAD);
  assign halted       = (state_reg == HALT);
  assign pc_load_data = load_data_reg;
  assign err          = err_reg;
  assign depth        = depth_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; a small counter model closes the pc loop.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        reset, start, jmp, call, ret, halt;
  logic [11:0] addr;
  logic [11:0] pc;
  logic        pc_en, pc_load, fetch, halted, err;
  logic [11:0] pc_load_data;
  logic [2:0]  depth;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  pc_sequencer dut (
    .CLK          (CLK),
    .reset        (reset),
    .start        (start),
    .jmp          (jmp),
    .call         (call),
    .ret          (ret),
    .halt         (halt),
    .addr         (addr),
    .pc           (pc),
    .pc_en        (pc_en),
    .pc_load      (pc_load),
    .pc_load_data (pc_load_data),
    .fetch        (fetch),
    .halted       (halted),
    .err          (err),
    .depth        (depth)
  );

  // External program counter
  always @(posedge CLK) begin
    if (reset)        pc <= 12'h000;
    else if (pc_load) pc <= pc_load_data;
    else if (pc_en)   pc <= pc + 12'd1;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    tests++;
    $display("[TB] %s observed=%h expected=%h", tag, obs, exp);
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_req();
    jmp = 0; call = 0; ret = 0; halt = 0;
  endtask

  initial begin
    reset = 1; start = 1; addr = 12'h000;
    clear_req();
    tick(); tick();
    check("rst_fetch", fetch, 0);
    check("rst_pc_en", pc_en, 0);
    check("rst_load", pc_load, 0);
    check("rst_halted", halted, 0);
    check("rst_err", err, 0);
    check("rst_data", pc_load_data, 12'h000);
    check("rst_depth", depth, 0);

    // start held through reset is honoured on the first edge after release
    reset = 0;
    tick();
    start = 0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      check($sformatf("seq_fetch_c%0d", i + 1), fetch, (i % 3 == 0) ? 12'd1 : 12'd0);
      check($sformatf("seq_pc_en_c%0d", i + 1), pc_en, (i % 3 == 2) ? 12'd1 : 12'd0);
    end
    tick(); tick();
    check("seq_pc", pc, 12'h003);

    // Jump
    jmp = 1; addr = 12'h080;
    tick(); clear_req();
    check("jmp_load", pc_load, 1);
    check("jmp_data", pc_load_data, 12'h080);
    check("jmp_pc_en", pc_en, 0);
    tick();
    check("jmp_fetch", fetch, 1);
    check("jmp_hold", pc_load_data, 12'h080);
    tick();

    // Call/return from pc=0x010
    jmp = 1; addr = 12'h010;
    tick(); clear_req(); tick(); tick();
    check("cr_pc", pc, 12'h010);
    call = 1; addr = 12'h200;
    tick(); clear_req();
    check("call_load", pc_load, 1);
    check("call_data", pc_load_data, 12'h200);
    check("call_depth", depth, 1);
    tick(); tick();
    ret = 1;
    tick(); clear_req();
    check("ret_load", pc_load, 1);
    check("ret_data", pc_load_data, 12'h011);
    check("ret_depth", depth, 0);
    tick(); tick();

    // Overflow: five nested calls
    for (int i = 0; i < 4; i++) begin
      call = 1; addr = 12'h100 + 12'(i);
      tick(); clear_req(); tick(); tick();
    end
    check("ovf_depth4", depth, 4);
    call = 1; addr = 12'h300;
    tick(); clear_req();
    check("ovf_err", err, 1);
    check("ovf_halted", halted, 1);
    check("ovf_depth", depth, 4);
    check("ovf_noload", pc_load, 0);
    check("ovf_data", pc_load_data, 12'h103);
    tick();
    check("ovf_stay", halted, 1);
    start = 1;
    tick(); start = 0;
    check("ovf_resume", fetch, 1);
    check("ovf_err_sticky", err, 1);
    tick();

    // Reset in the middle of a LOAD
    ret = 1;
    tick(); clear_req();
    check("mid_load", pc_load, 1);
    check("mid_depth", depth, 3);
    reset = 1;
    tick(); reset = 0;
    check("mrst_load", pc_load, 0);
    check("mrst_fetch", fetch, 0);
    check("mrst_err", err, 0);
    check("mrst_depth", depth, 0);
    check("mrst_data", pc_load_data, 12'h000);
    tick();
    check("mrst_idle", fetch, 0);

    // Underflow
    start = 1;
    tick(); start = 0; tick();
    ret = 1;
    tick(); clear_req();
    check("unf_err", err, 1);
    check("unf_halted", halted, 1);
    check("unf_noload", pc_load, 0);
    check("unf_depth", depth, 0);

    // halt beats jmp
    start = 1;
    tick(); start = 0; tick();
    halt = 1; jmp = 1; addr = 12'h123;
    tick(); clear_req();
    check("pri_halted", halted, 1);
    check("pri_noload", pc_load, 0);
    check("pri_data", pc_load_data, 12'h000);
    check("pri_err_sticky", err, 1);

    // Call at pc=0xFFF pushes 0x000; ret beats call on the pop
    start = 1;
    tick(); start = 0; tick();
    jmp = 1; addr = 12'hFFF;
    tick(); clear_req(); tick(); tick();
    check("wrap_pc", pc, 12'hFFF);
    call = 1; addr = 12'h300;
    tick(); clear_req();
    check("wrap_call_data", pc_load_data, 12'h300);
    check("wrap_depth", depth, 1);
    tick(); tick();
    ret = 1; call = 1; addr = 12'h555;
    tick(); clear_req();
    check("wrap_ret_load", pc_load, 1);
    check("wrap_ret_data", pc_load_data, 12'h000);
    check("wrap_ret_depth", depth, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high; overrides every other input.
REQ-004 start  input  1  leave IDLE or HALT and begin fetching.
REQ-005 jmp  input  1  EXEC-cycle request: unconditional jump to addr.
REQ-006 call  input  1  EXEC-cycle request: push return address, jump to addr.
REQ-007 ret  input  1  EXEC-cycle request: pop return address and load it.
REQ-008 halt  input  1  EXEC-cycle request: stop in HALT.
REQ-009 addr  input  12  jump/call target, sampled in EXEC.
REQ-010 pc  input  12  current program counter value (counter out).
REQ-011 pc_en  output  1  counter enable (increment by one).
REQ-012 pc_load  output  1  counter load strobe.
REQ-013 pc_load_data  output  12  counter load value.
REQ-014 fetch  output  1  instruction-memory read strobe.
REQ-015 halted  output  1  high while in HALT.
REQ-016 err  output  1  sticky stack overflow/underflow flag.
REQ-017 depth  output  3  return-stack occupancy, 0..4.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, EXEC, ADV, LOAD and HALT.
REQ-019 Outputs SHALL be Moore: fetch=1 only in FETCH, pc_en=1 only in ADV, pc_load=1 only in LOAD, halted=1 only in HALT.
REQ-020 IDLE: start=1 -> FETCH; otherwise stay.
REQ-021 FETCH -> EXEC unconditionally after one cycle.
REQ-022 EXEC priority SHALL be halt > ret > call > jmp > none; lower-priority requests in the same cycle are ignored.
REQ-023 EXEC, none -> ADV; ADV -> FETCH; one instruction without a branch takes 3 cycles.
REQ-024 EXEC, jmp -> LOAD with pc_load_data=addr; LOAD -> FETCH.
REQ-025 EXEC, call with depth<4 -> push (pc+1) mod 4096, depth+1, pc_load_data=addr, LOAD.
REQ-026 EXEC, ret with depth>0 -> pop top entry into pc_load_data, depth-1, LOAD.
REQ-027 The return stack SHALL be 4 entries x 12 bits, LIFO.
REQ-028 Call with depth=4 (overflow) -> no push, err=1, HALT.
REQ-029 Ret with depth=0 (underflow) -> no pop, err=1, HALT.
REQ-030 EXEC, halt -> HALT; pc is not advanced.
REQ-031 HALT: start=1 -> FETCH with stack and err unchanged; otherwise stay.
REQ-032 pc=4095 in EXEC with a call SHALL push 0 (12-bit wrap).
REQ-033 pc_load_data SHALL hold its last value outside LOAD.
REQ-034 pc_en and pc_load SHALL never be high in the same cycle.
REQ-035 err SHALL be cleared only by reset.

Reset
REQ-036 reset=1 at any edge, in any state including mid-instruction, SHALL give the next state IDLE.
REQ-037 Reset SHALL set pc_en, pc_load, fetch, halted and err to 0, pc_load_data=12'h000 and depth=0.
REQ-038 Reset SHALL clear the return-stack contents to 0.
REQ-039 Reset asserted together with start SHALL leave the block in IDLE; start is honoured only from the following cycle.

Verification
REQ-040 Reset then start, no requests for 9 cycles -> fetch/pc_en pattern 1,0,0 repeated three times; pc_en pulses on cycles 3, 6 and 9.
REQ-041 Jump: jmp=1 with addr=12'h080 in EXEC -> the next cycle has pc_load=1, pc_load_data=12'h080 and pc_en=0, followed by FETCH.
REQ-042 Call/return: pc=12'h010, call with addr=12'h200 -> depth=1, load 12'h200; a later ret -> load 12'h011, depth=0.
REQ-043 Overflow: five nested calls -> fifth call gives err=1, halted=1, depth=4, no load; start then resumes FETCH with err still 1.
REQ-044 Underflow and priority: ret at depth 0 -> err=1, HALT; halt+jmp together in EXEC -> HALT, with no pc_load.
REQ-045 Reset mid-LOAD -> the next cycle has all outputs 0, depth=0, state IDLE; pc=12'hFFF with a call -> the pushed value is 12'h000.
